// File: rtl/axi_pkg.sv
// Shared AXI4 definitions: burst types, response codes, transfer sizes and
// the FSM state encodings of the SRAM responder.
package axi_pkg;

   typedef enum logic [1:0] {
      BURST_FIXED = 2'b00,
      BURST_INCR  = 2'b01,
      BURST_WRAP  = 2'b10
   } burst_e;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam logic [2:0] SIZE_1B  = 3'd0;
   localparam logic [2:0] SIZE_2B  = 3'd1;
   localparam logic [2:0] SIZE_4B  = 3'd2;
   // Widest transfer the 32-bit data path can carry.
   localparam logic [2:0] SIZE_MAX = SIZE_4B;

   typedef enum logic [1:0] {
      W_IDLE,
      W_DATA,
      W_RESP
   } w_state_e;

   typedef enum logic [0:0] {
      R_IDLE,
      R_DATA
   } r_state_e;

endpackage

// File: rtl/axi_burst_addr.sv
// Next-beat address generator for one AXI channel. WRAP, the reserved burst
// encoding and sizes wider than the bus are flagged as unsupported.
module axi_burst_addr
   import axi_pkg::*;
(
   input  logic [31:0] addr,
   input  logic [2:0]  size,
   input  logic [1:0]  burst,
   output logic [31:0] next_addr,
   output logic        unsupported
);

   // Step the address for INCR, hold it for FIXED and everything else.
   always_comb begin
      // NOTE: every output gets a default before any branch, otherwise an
      // untaken branch would leave it holding its value and infer a latch.
      next_addr   = addr;
      unsupported = (size > SIZE_MAX) ||
                    !((burst == BURST_FIXED) || (burst == BURST_INCR));
      if (burst == BURST_INCR) begin
         next_addr = addr + (32'd1 << size);
      end
   end

endmodule

// File: rtl/axi_sram_slave.sv
// AXI4 memory responder: one read and one write burst in flight at a time,
// on independent channels, backed by a 1R1W word array with read-first
// behaviour on a same-edge collision.
module axi_sram_slave
   import axi_pkg::*;
#(
   parameter int          MEM_WORDS = 4096,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          ID_WIDTH  = 4
) (
   input  logic                clk,
   input  logic                reset,
   // write address
   input  logic [ID_WIDTH-1:0] AWID,
   input  logic [31:0]         AWADDR,
   input  logic [7:0]          AWLEN,
   input  logic [2:0]          AWSIZE,
   input  logic [1:0]          AWBURST,
   input  logic                AWLOCK,
   input  logic [3:0]          AWCACHE,
   input  logic [2:0]          AWPROT,
   input  logic [3:0]          AWQOS,
   input  logic                AWVALID,
   output logic                AWREADY,
   // write data
   input  logic [31:0]         WDATA,
   input  logic [3:0]          WSTRB,
   input  logic                WLAST,
   input  logic                WVALID,
   output logic                WREADY,
   // write response
   output logic [ID_WIDTH-1:0] BID,
   output logic [1:0]          BRESP,
   output logic                BVALID,
   input  logic                BREADY,
   // read address
   input  logic [ID_WIDTH-1:0] ARID,
   input  logic [31:0]         ARADDR,
   input  logic [7:0]          ARLEN,
   input  logic [2:0]          ARSIZE,
   input  logic [1:0]          ARBURST,
   input  logic                ARLOCK,
   input  logic [3:0]          ARCACHE,
   input  logic [2:0]          ARPROT,
   input  logic [3:0]          ARQOS,
   input  logic                ARVALID,
   output logic                ARREADY,
   // read data
   output logic [ID_WIDTH-1:0] RID,
   output logic [31:0]         RDATA,
   output logic [1:0]          RRESP,
   output logic                RLAST,
   output logic                RVALID,
   input  logic                RREADY
);

   localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

   // Lock, cache, protection and QoS attributes carry no meaning for a plain
   // memory and are deliberately dropped.
   logic unused_attr;
   assign unused_attr = ^{AWLOCK, AWCACHE, AWPROT, AWQOS,
                          ARLOCK, ARCACHE, ARPROT, ARQOS};

   function automatic logic in_range(input logic [31:0] a);
      return (a >= BASE_ADDR) && (((a - BASE_ADDR) >> 2) < 32'(MEM_WORDS));
   endfunction

   function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] a);
      return IDX_W'((a - BASE_ADDR) >> 2);
   endfunction

   logic [31:0] mem [MEM_WORDS];

   // ------------------------------------------------------------------
   // Write channel
   // ------------------------------------------------------------------
   w_state_e            w_state, w_state_nxt;
   logic [ID_WIDTH-1:0] w_id;
   logic [31:0]         w_addr, w_next_addr;
   logic [7:0]          w_cnt;
   logic [2:0]          w_size;
   logic [1:0]          w_burst;
   logic                w_err, w_unsup, w_beat_err;
   logic                aw_hs, w_hs, w_last, b_hs;

   axi_burst_addr u_w_addr (
      .addr        (w_addr),
      .size        (w_size),
      .burst       (w_burst),
      .next_addr   (w_next_addr),
      .unsupported (w_unsup)
   );

   assign aw_hs      = AWVALID && AWREADY;
   assign w_hs       = WVALID && WREADY;
   // WLAST or an exhausted count closes the burst, whichever comes first.
   assign w_last     = w_hs && (WLAST || (w_cnt == 8'd0));
   assign b_hs       = BVALID && BREADY;
   assign w_beat_err = w_unsup || !in_range(w_addr);

   // Write state register.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignment so every flop
      // samples pre-edge values regardless of block evaluation order.
      if (reset) w_state <= W_IDLE;
      else       w_state <= w_state_nxt;
   end

   // Write next-state logic.
   always_comb begin
      w_state_nxt = w_state;
      case (w_state)
         W_IDLE:  if (aw_hs)  w_state_nxt = W_DATA;
         W_DATA:  if (w_last) w_state_nxt = W_RESP;
         W_RESP:  if (b_hs)   w_state_nxt = W_IDLE;
         default:             w_state_nxt = W_IDLE;
      endcase
   end

   // Write channel outputs.
   always_comb begin
      AWREADY = (w_state == W_IDLE) && !reset;
      WREADY  = (w_state == W_DATA);
      BVALID  = (w_state == W_RESP);
      BID     = w_id;
      BRESP   = w_err ? RESP_SLVERR : RESP_OKAY;
   end

   // Write burst context: latched on AW, advanced on each W beat.
   always_ff @(posedge clk) begin
      if (reset) begin
         w_id    <= '0;
         w_addr  <= '0;
         w_cnt   <= '0;
         w_size  <= '0;
         w_burst <= '0;
         w_err   <= 1'b0;
      end else if (aw_hs) begin
         w_id    <= AWID;
         w_addr  <= AWADDR;
         w_cnt   <= AWLEN;
         w_size  <= AWSIZE;
         w_burst <= AWBURST;
         w_err   <= 1'b0;
      end else if (w_hs) begin
         w_addr  <= w_next_addr;
         w_cnt   <= w_cnt - 8'd1;
         w_err   <= w_err | w_beat_err;
      end
   end

   // Byte-lane write port of the array.
   always_ff @(posedge clk) begin
      // NOTE: the array has no reset; its contents survive reset and it maps
      // onto block RAM.
      if (w_hs && !w_beat_err && !reset) begin
         for (int b = 0; b < 4; b++) begin
            if (WSTRB[b]) mem[word_idx(w_addr)][8*b +: 8] <= WDATA[8*b +: 8];
         end
      end
   end

   // ------------------------------------------------------------------
   // Read channel
   // ------------------------------------------------------------------
   r_state_e            r_state, r_state_nxt;
   logic [ID_WIDTH-1:0] r_id;
   logic [31:0]         r_addr, r_next_addr, load_addr;
   logic [7:0]          r_cnt;
   logic [2:0]          r_size, ba_size;
   logic [1:0]          r_burst, ba_burst;
   logic [31:0]         ba_addr;
   logic [31:0]         rdata_q;
   logic [1:0]          rresp_q;
   logic                rlast_q, r_unsup, load_err;
   logic                ar_hs, r_hs, r_last_hs;

   // While idle the generator checks the incoming AR request; during the
   // burst it steps the latched one.
   assign ba_addr  = (r_state == R_IDLE) ? ARADDR  : r_addr;
   assign ba_size  = (r_state == R_IDLE) ? ARSIZE  : r_size;
   assign ba_burst = (r_state == R_IDLE) ? ARBURST : r_burst;

   axi_burst_addr u_r_addr (
      .addr        (ba_addr),
      .size        (ba_size),
      .burst       (ba_burst),
      .next_addr   (r_next_addr),
      .unsupported (r_unsup)
   );

   assign ar_hs     = ARVALID && ARREADY;
   assign r_hs      = RVALID && RREADY;
   assign r_last_hs = r_hs && rlast_q;
   assign load_addr = (r_state == R_IDLE) ? ARADDR : r_next_addr;
   assign load_err  = r_unsup || !in_range(load_addr);

   // Read state register.
   always_ff @(posedge clk) begin
      if (reset) r_state <= R_IDLE;
      else       r_state <= r_state_nxt;
   end

   // Read next-state logic.
   always_comb begin
      r_state_nxt = r_state;
      case (r_state)
         R_IDLE:  if (ar_hs)     r_state_nxt = R_DATA;
         R_DATA:  if (r_last_hs) r_state_nxt = R_IDLE;
         default:                r_state_nxt = R_IDLE;
      endcase
   end

   // Read channel outputs.
   always_comb begin
      ARREADY = (r_state == R_IDLE) && !reset;
      RVALID  = (r_state == R_DATA);
      RID     = r_id;
      RDATA   = rdata_q;
      RRESP   = rresp_q;
      RLAST   = rlast_q;
   end

   // Read burst context and beat register: beat 0 loads on AR, each later
   // beat loads on the handshake of the one before, so a stall holds all.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_id    <= '0;
         r_addr  <= '0;
         r_cnt   <= '0;
         r_size  <= '0;
         r_burst <= '0;
         rdata_q <= '0;
         rresp_q <= RESP_OKAY;
         rlast_q <= 1'b0;
      end else if (ar_hs) begin
         r_id    <= ARID;
         r_addr  <= ARADDR;
         r_cnt   <= ARLEN;
         r_size  <= ARSIZE;
         r_burst <= ARBURST;
         rdata_q <= load_err ? 32'd0 : mem[word_idx(load_addr)];
         rresp_q <= load_err ? RESP_SLVERR : RESP_OKAY;
         rlast_q <= (ARLEN == 8'd0);
      end else if (r_hs && !rlast_q) begin
         r_addr  <= r_next_addr;
         r_cnt   <= r_cnt - 8'd1;
         rdata_q <= load_err ? 32'd0 : mem[word_idx(load_addr)];
         rresp_q <= load_err ? RESP_SLVERR : RESP_OKAY;
         rlast_q <= (r_cnt == 8'd1);
      end
   end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Scoreboard bench for axi_sram_slave: stimulus tasks push the expected B
// and R responses, a negedge monitor pops and compares them.
module tb_axi_sram_slave;

   localparam int          MEM_WORDS = 4096;
   localparam logic [31:0] BASE_ADDR = 32'h0000_0000;
   localparam int          ID_WIDTH  = 4;
   localparam logic [1:0]  FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10;
   localparam logic [1:0]  OKAY = 2'b00, SLVERR = 2'b10;

   typedef struct {
      logic [3:0] id;
      logic [1:0] resp;
   } b_exp_t;

   typedef struct {
      logic [31:0] data;
      logic [1:0]  resp;
      logic        last;
      logic [3:0]  id;
   } r_exp_t;

   logic                clk = 1'b0;
   logic                reset;
   logic [ID_WIDTH-1:0] AWID, ARID, BID, RID;
   logic [31:0]         AWADDR, ARADDR, WDATA, RDATA;
   logic [7:0]          AWLEN, ARLEN;
   logic [2:0]          AWSIZE, ARSIZE;
   logic [1:0]          AWBURST, ARBURST, BRESP, RRESP;
   logic                AWVALID, AWREADY, WLAST, WVALID, WREADY;
   logic                BVALID, BREADY, ARVALID, ARREADY;
   logic                RLAST, RVALID, RREADY;
   logic [3:0]          WSTRB;

   int checks = 0;
   int errors = 0;

   b_exp_t exp_b[$];
   r_exp_t exp_r[$];
   b_exp_t eb;
   r_exp_t er;

   always #5 clk = ~clk;

   axi_sram_slave #(
      .MEM_WORDS (MEM_WORDS),
      .BASE_ADDR (BASE_ADDR),
      .ID_WIDTH  (ID_WIDTH)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .AWID    (AWID),
      .AWADDR  (AWADDR),
      .AWLEN   (AWLEN),
      .AWSIZE  (AWSIZE),
      .AWBURST (AWBURST),
      .AWLOCK  (1'b0),
      .AWCACHE (4'd0),
      .AWPROT  (3'd0),
      .AWQOS   (4'd0),
      .AWVALID (AWVALID),
      .AWREADY (AWREADY),
      .WDATA   (WDATA),
      .WSTRB   (WSTRB),
      .WLAST   (WLAST),
      .WVALID  (WVALID),
      .WREADY  (WREADY),
      .BID     (BID),
      .BRESP   (BRESP),
      .BVALID  (BVALID),
      .BREADY  (BREADY),
      .ARID    (ARID),
      .ARADDR  (ARADDR),
      .ARLEN   (ARLEN),
      .ARSIZE  (ARSIZE),
      .ARBURST (ARBURST),
      .ARLOCK  (1'b0),
      .ARCACHE (4'd0),
      .ARPROT  (3'd0),
      .ARQOS   (4'd0),
      .ARVALID (ARVALID),
      .ARREADY (ARREADY),
      .RID     (RID),
      .RDATA   (RDATA),
      .RRESP   (RRESP),
      .RLAST   (RLAST),
      .RVALID  (RVALID),
      .RREADY  (RREADY)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_b(input logic [3:0] id, input logic [1:0] resp);
      exp_b.push_back('{id: id, resp: resp});
   endtask

   task automatic push_r(input logic [31:0] data, input logic [1:0] resp,
                         input logic last, input logic [3:0] id);
      exp_r.push_back('{data: data, resp: resp, last: last, id: id});
   endtask

   // Monitor: pop on accepted beats, compare the head without popping while
   // the master stalls so held data is checked every cycle.
   always @(negedge clk) begin
      if (!reset) begin
         if (BVALID && BREADY) begin
            if (exp_b.size() == 0) check("b_unexpected", 32'(BVALID), 32'd0);
            else begin
               eb = exp_b.pop_front();
               check("bid", 32'(BID), 32'(eb.id));
               check("bresp", 32'(BRESP), 32'(eb.resp));
            end
         end
         if (RVALID) begin
            if (exp_r.size() == 0) check("r_unexpected", 32'(RVALID), 32'd0);
            else begin
               er = RREADY ? exp_r.pop_front() : exp_r[0];
               check(RREADY ? "rdata" : "rdata_stall", RDATA, er.data);
               check(RREADY ? "rresp" : "rresp_stall", 32'(RRESP), 32'(er.resp));
               check(RREADY ? "rlast" : "rlast_stall", 32'(RLAST), 32'(er.last));
               check(RREADY ? "rid" : "rid_stall", 32'(RID), 32'(er.id));
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // All tasks start and end 1 time unit after a rising edge.
   task automatic aw(input logic [3:0] id, input logic [31:0] addr,
                     input logic [7:0] len, input logic [1:0] burst);
      int n = 0;
      AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = 3'd2; AWBURST = burst;
      AWVALID = 1'b1;
      do begin @(negedge clk); n++; end while (!AWREADY && n < 100);
      check("awready", 32'(AWREADY), 32'd1);
      @(posedge clk); #1;
      AWVALID = 1'b0;
   endtask

   task automatic w_beat(input logic [31:0] data, input logic [3:0] strb, input logic last);
      int n = 0;
      WDATA = data; WSTRB = strb; WLAST = last; WVALID = 1'b1;
      do begin @(negedge clk); n++; end while (!WREADY && n < 100);
      check("wready", 32'(WREADY), 32'd1);
      @(posedge clk); #1;
      WVALID = 1'b0; WLAST = 1'b0;
   endtask

   task automatic wait_b();
      int n = 0;
      while (exp_b.size() != 0 && n < 50) begin @(negedge clk); n++; end
      check("b_drained", 32'(exp_b.size()), 32'd0);
      @(posedge clk); #1;
   endtask

   // Issue an AR and drive RREADY from pat (bit 0 first, one bit per cycle
   // starting with the beat-0 cycle), then RREADY=1 until the burst ends.
   task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input logic [7:0] pat, input int npat);
      int n = 0;
      ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = 3'd2; ARBURST = burst;
      ARVALID = 1'b1;
      do begin @(negedge clk); n++; end while (!ARREADY && n < 100);
      check("arready", 32'(ARREADY), 32'd1);
      @(posedge clk); #1;
      ARVALID = 1'b0;
      RREADY  = pat[0];
      @(negedge clk);
      check("r_latency", 32'(RVALID), 32'd1);
      for (int i = 1; i < npat; i++) begin
         @(posedge clk); #1;
         RREADY = pat[i];
      end
      RREADY = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (RVALID && n < 600);
      check("r_done", 32'(RVALID), 32'd0);
      check("r_drained", 32'(exp_r.size()), 32'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      reset = 1'b1;
      AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0; AWVALID = 1'b0;
      WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b1;
      ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARBURST = '0; ARVALID = 1'b0;
      RREADY = 1'b1;

      // Reset values
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_awready", 32'(AWREADY), 32'd0);
      check("rst_arready", 32'(ARREADY), 32'd0);
      check("rst_wready", 32'(WREADY), 32'd0);
      check("rst_bvalid", 32'(BVALID), 32'd0);
      check("rst_rvalid", 32'(RVALID), 32'd0);
      check("rst_rdata", RDATA, 32'd0);
      check("rst_rlast", 32'(RLAST), 32'd0);
      check("rst_rresp", 32'(RRESP), 32'd0);
      check("rst_bresp", 32'(BRESP), 32'd0);
      check("rst_rid", 32'(RID), 32'd0);
      check("rst_bid", 32'(BID), 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check("post_rst_awready", 32'(AWREADY), 32'd1);
      check("post_rst_arready", 32'(ARREADY), 32'd1);
      @(posedge clk); #1;

      // Single write then read
      push_b(4'd1, OKAY);
      aw(4'd1, 32'h100, 8'd0, FIXED);
      @(negedge clk);
      check("wready_latency", 32'(WREADY), 32'd1);
      @(posedge clk); #1;
      w_beat(32'hDEADBEEF, 4'b1111, 1'b1);
      @(negedge clk);
      check("bvalid_latency", 32'(BVALID), 32'd1);
      @(posedge clk); #1;
      wait_b();
      push_r(32'hDEADBEEF, OKAY, 1'b1, 4'd2);
      do_read(4'd2, 32'h100, 8'd0, INCR, 8'b1, 1);

      // Byte strobes
      push_b(4'd1, OKAY);
      aw(4'd1, 32'h200, 8'd0, INCR);
      w_beat(32'h11223344, 4'b1111, 1'b1);
      wait_b();
      push_b(4'd2, OKAY);
      aw(4'd2, 32'h200, 8'd0, INCR);
      w_beat(32'hAABBCCDD, 4'b0101, 1'b1);
      wait_b();
      push_r(32'h11BB33DD, OKAY, 1'b1, 4'd0);
      do_read(4'd0, 32'h200, 8'd0, INCR, 8'b1, 1);

      // INCR burst with RREADY pattern 1,0,1,1,0,1
      push_b(4'd3, OKAY);
      aw(4'd3, 32'h40, 8'd3, INCR);
      for (int i = 0; i < 4; i++) w_beat(32'hA000_0000 + 32'(i), 4'b1111, i == 3);
      wait_b();
      for (int i = 0; i < 4; i++) push_r(32'hA000_0000 + 32'(i), OKAY, i == 3, 4'd5);
      do_read(4'd5, 32'h40, 8'd3, INCR, 8'b0010_1101, 6);

      // Out-of-range read and unsupported WRAP write
      push_r(32'd0, SLVERR, 1'b1, 4'd3);
      do_read(4'd3, BASE_ADDR + 32'(4 * MEM_WORDS), 8'd0, INCR, 8'b1, 1);
      push_b(4'hA, SLVERR);
      aw(4'hA, 32'h100, 8'd1, WRAP);
      w_beat(32'h12345678, 4'b1111, 1'b0);
      w_beat(32'h12345678, 4'b1111, 1'b1);
      wait_b();
      push_r(32'hDEADBEEF, OKAY, 1'b1, 4'd4);
      do_read(4'd4, 32'h100, 8'd0, INCR, 8'b1, 1);

      // Read-first collision at 0x80
      push_b(4'd6, OKAY);
      aw(4'd6, 32'h80, 8'd0, INCR);
      w_beat(32'h5555AAAA, 4'b1111, 1'b1);
      wait_b();
      push_b(4'd7, OKAY);
      push_r(32'h5555AAAA, OKAY, 1'b1, 4'd8);
      aw(4'd7, 32'h80, 8'd0, INCR);
      WDATA = 32'h77777777; WSTRB = 4'b1111; WLAST = 1'b1; WVALID = 1'b1;
      ARID = 4'd8; ARADDR = 32'h80; ARLEN = 8'd0; ARSIZE = 3'd2; ARBURST = INCR;
      ARVALID = 1'b1;
      @(negedge clk);
      check("collide_wready", 32'(WREADY), 32'd1);
      check("collide_arready", 32'(ARREADY), 32'd1);
      @(posedge clk); #1;
      WVALID = 1'b0; WLAST = 1'b0; ARVALID = 1'b0;
      @(negedge clk);
      check("collide_rvalid", 32'(RVALID), 32'd1);
      @(posedge clk); #1;
      wait_b();
      push_r(32'h77777777, OKAY, 1'b1, 4'd9);
      do_read(4'd9, 32'h80, 8'd0, INCR, 8'b1, 1);

      // Reset during beat 2 of a len-7 read
      push_b(4'd4, OKAY);
      aw(4'd4, 32'h300, 8'd7, INCR);
      for (int i = 0; i < 8; i++) w_beat(32'hC0DE_0000 + 32'(i), 4'b1111, i == 7);
      wait_b();
      for (int i = 0; i < 3; i++) push_r(32'hC0DE_0000 + 32'(i), OKAY, 1'b0, 4'd6);
      ARID = 4'd6; ARADDR = 32'h300; ARLEN = 8'd7; ARSIZE = 3'd2; ARBURST = INCR;
      ARVALID = 1'b1;
      @(negedge clk);
      check("rst_rd_arready", 32'(ARREADY), 32'd1);
      @(posedge clk); #1;
      ARVALID = 1'b0; RREADY = 1'b1;
      @(posedge clk); #1;
      RREADY = 1'b1;
      @(posedge clk); #1;
      RREADY = 1'b0;
      @(negedge clk);
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      check("mid_rst_arready", 32'(ARREADY), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      check("rvalid_after_reset", 32'(RVALID), 32'd0);
      exp_r.delete();
      @(posedge clk); #1;
      reset = 1'b0; RREADY = 1'b1;
      @(negedge clk);
      check("arready_after_reset", 32'(ARREADY), 32'd1);
      @(posedge clk); #1;
      for (int i = 0; i < 8; i++) push_r(32'hC0DE_0000 + 32'(i), OKAY, i == 7, 4'd6);
      do_read(4'd6, 32'h300, 8'd7, INCR, 8'b1, 1);
      push_r(32'h11BB33DD, OKAY, 1'b1, 4'd1);
      do_read(4'd1, 32'h200, 8'd0, FIXED, 8'b1, 1);

      check("b_queue_empty", 32'(exp_b.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
